// File: rtl/seq_slice_alu_if.sv
// Handshake and data bundle for seq_slice_alu.
// The master drives the operation request; the slave returns the result and flags.
interface seq_slice_alu_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [4:0]       select;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             acc_sel;
   logic [WIDTH-1:0] y;
   logic             cout;
   logic             zero;
   logic             ovf;
   logic             illegal;
   logic             busy;
   logic             done;

   modport master (
      output start, select, a, b, cin, acc_sel,
      input  y, cout, zero, ovf, illegal, busy, done
   );

   modport slave (
      input  start, select, a, b, cin, acc_sel,
      output y, cout, zero, ovf, illegal, busy, done
   );
endinterface

// File: rtl/seq_slice_alu.sv
// Digit-serial ALU: one SLICE-bit datapath reused over WIDTH/SLICE cycles,
// least significant digit first, carry registered between digits.
// Optional accumulate mode (operand A taken from the held y) is enabled by
// defining SEQ_SLICE_ALU_ACC_EN; otherwise acc_sel is ignored.
module seq_slice_alu #(
   parameter int WIDTH = 16,
   parameter int SLICE = 1
) (
   input logic            clk,
   input logic            rst,
   seq_slice_alu_if.slave bus
);
   localparam int STEPS = WIDTH / SLICE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_ADC   = 5'd2;
   localparam logic [4:0] OP_SBB   = 5'd3;
   localparam logic [4:0] OP_INC   = 5'd4;
   localparam logic [4:0] OP_DEC   = 5'd5;
   localparam logic [4:0] OP_AND   = 5'd6;
   localparam logic [4:0] OP_OR    = 5'd7;
   localparam logic [4:0] OP_XOR   = 5'd8;
   localparam logic [4:0] OP_NAND  = 5'd9;
   localparam logic [4:0] OP_NOR   = 5'd10;
   localparam logic [4:0] OP_XNOR  = 5'd11;
   localparam logic [4:0] OP_NOTA  = 5'd12;
   localparam logic [4:0] OP_PASSA = 5'd13;
   localparam logic [4:0] OP_PASSB = 5'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Operand shift registers and the result being assembled
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] a_in;
   logic [4:0]       op;
   logic             carry;
   logic             msb_ovf;

   // Registered outputs
   logic [WIDTH-1:0] y_r;
   logic             cout_r;
   logic             zero_r;
   logic             ovf_r;
   logic             ill_r;
   logic             busy_r;
   logic             done_r;

   // Single-digit datapath
   logic [SLICE-1:0] a_dig;
   logic [SLICE-1:0] b_dig;
   logic [SLICE-1:0] b_eff;
   logic [SLICE-1:0] logic_dig;
   logic [SLICE-1:0] digit;
   logic [SLICE:0]   sum;
   logic             msb_cin;
   logic             arith;
   logic             op_illegal;
   logic             accept;
   logic             init_carry;

   assign accept     = (state == IDLE) && bus.start;
   assign arith      = (op <= OP_DEC);
   assign op_illegal = (op > OP_PASSB);
   assign a_dig      = a_sh[SLICE-1:0];
   assign b_dig      = b_sh[SLICE-1:0];

`ifdef SEQ_SLICE_ALU_ACC_EN
   assign a_in = bus.acc_sel ? y_r : bus.a;
`else
   logic unused_acc_sel;
   assign unused_acc_sel = bus.acc_sel;
   assign a_in = bus.a;
`endif

   // Carry seeded into the first digit, chosen from the incoming opcode
   always_comb begin
      init_carry = 1'b0;
      case (bus.select)
         OP_SUB, OP_INC: init_carry = 1'b1;
         OP_ADC, OP_SBB: init_carry = bus.cin;
         default:        init_carry = 1'b0;
      endcase
   end

   // One digit of the selected operation; B is reshaped so every arithmetic op is an add
   always_comb begin
      b_eff     = b_dig;
      logic_dig = '0;
      case (op)
         OP_SUB, OP_SBB: b_eff = ~b_dig;
         OP_INC:         b_eff = '0;
         OP_DEC:         b_eff = '1;
         default:        b_eff = b_dig;
      endcase
      case (op)
         OP_AND:   logic_dig = a_dig & b_dig;
         OP_OR:    logic_dig = a_dig | b_dig;
         OP_XOR:   logic_dig = a_dig ^ b_dig;
         OP_NAND:  logic_dig = ~(a_dig & b_dig);
         OP_NOR:   logic_dig = ~(a_dig | b_dig);
         OP_XNOR:  logic_dig = ~(a_dig ^ b_dig);
         OP_NOTA:  logic_dig = ~a_dig;
         OP_PASSA: logic_dig = a_dig;
         OP_PASSB: logic_dig = b_dig;
         default:  logic_dig = '0;
      endcase
      sum      = {1'b0, a_dig} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry};
      msb_cin  = a_dig[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
      digit    = arith ? sum[SLICE-1:0] : logic_dig;
      res_next = (res >> SLICE) | (WIDTH'(digit) << (WIDTH - SLICE));
   end

   // Datapath registers: latch operands on accept, then shift one digit per RUN cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh  <= a_in;
         b_sh  <= bus.b;
         op    <= bus.select;
         carry <= init_carry;
      end else if (state == RUN) begin
         a_sh    <= a_sh >> SLICE;
         b_sh    <= b_sh >> SLICE;
         res     <= res_next;
         carry   <= arith ? sum[SLICE] : 1'b0;
         msb_ovf <= msb_cin ^ sum[SLICE];
      end
   end

   // Control FSM with registered result, flags and handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         y_r    <= '0;
         cout_r <= 1'b0;
         zero_r <= 1'b1;
         ovf_r  <= 1'b0;
         ill_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIN: begin
               if (op_illegal) begin
                  y_r    <= '0;
                  cout_r <= 1'b0;
                  zero_r <= 1'b1;
                  ovf_r  <= 1'b0;
                  ill_r  <= 1'b1;
               end else begin
                  y_r    <= res;
                  cout_r <= arith & carry;
                  zero_r <= (res == '0);
                  ovf_r  <= arith & msb_ovf;
                  ill_r  <= 1'b0;
               end
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.y       = y_r;
   assign bus.cout    = cout_r;
   assign bus.zero    = zero_r;
   assign bus.ovf     = ovf_r;
   assign bus.illegal = ill_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
endmodule

// File: tb/tb_seq_slice_alu.sv
// Bench for seq_slice_alu: a bit-serial (SLICE=1) and a nibble-serial (SLICE=4)
// instance share one stimulus stream and are scored against a word-level model.
module tb_seq_slice_alu;
   typedef struct packed {
      logic [15:0] y;
      logic        cout;
      logic        zero;
      logic        ovf;
      logic        ill;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        cin = 1'b0;
   logic        acc_sel = 1'b0;
   logic [4:0]  select = 5'd0;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] model_y = 16'h0;
   res_t        q1[$];
   res_t        q4[$];

   always #5 clk = ~clk;

   seq_slice_alu_if #(.WIDTH(16)) i1 ();
   seq_slice_alu_if #(.WIDTH(16)) i4 ();

   assign i1.start = start;  assign i4.start = start;
   assign i1.select = select; assign i4.select = select;
   assign i1.a = a;          assign i4.a = a;
   assign i1.b = b;          assign i4.b = b;
   assign i1.cin = cin;      assign i4.cin = cin;
   assign i1.acc_sel = acc_sel; assign i4.acc_sel = acc_sel;

   seq_slice_alu #(.WIDTH(16), .SLICE(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
   seq_slice_alu #(.WIDTH(16), .SLICE(4)) u4 (.clk(clk), .rst(rst), .bus(i4));

   // Word-level reference of the opcode table
   function automatic res_t model(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                                  input logic cv);
      res_t        r;
      logic [16:0] s;
      logic [15:0] bx;
      logic        ci;
      logic        ar;
      r  = '0;
      bx = bv;
      ci = 1'b0;
      ar = 1'b1;
      case (op)
         5'd0: begin bx = bv;       ci = 1'b0; end
         5'd1: begin bx = ~bv;      ci = 1'b1; end
         5'd2: begin bx = bv;       ci = cv;   end
         5'd3: begin bx = ~bv;      ci = cv;   end
         5'd4: begin bx = 16'h0;    ci = 1'b1; end
         5'd5: begin bx = 16'hFFFF; ci = 1'b0; end
         default: ar = 1'b0;
      endcase
      if (ar) begin
         s      = {1'b0, av} + {1'b0, bx} + {16'h0, ci};
         r.y    = s[15:0];
         r.cout = s[16];
         r.ovf  = (av[15] == bx[15]) && (s[15] != av[15]);
      end else begin
         case (op)
            5'd6:  r.y = av & bv;
            5'd7:  r.y = av | bv;
            5'd8:  r.y = av ^ bv;
            5'd9:  r.y = ~(av & bv);
            5'd10: r.y = ~(av | bv);
            5'd11: r.y = ~(av ^ bv);
            5'd12: r.y = ~av;
            5'd13: r.y = av;
            5'd14: r.y = bv;
            default: begin r.y = 16'h0; r.ill = 1'b1; end
         endcase
      end
      r.zero = (r.y == 16'h0);
      return r;
   endfunction

   // Called at a negedge: presents one operation and pushes its expected result
   task automatic drive_op(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic acc, input bit push);
      res_t        e;
      logic [15:0] a_eff;
      a_eff = av;
`ifdef SEQ_SLICE_ALU_ACC_EN
      if (acc) a_eff = model_y;
`endif
      e = model(op, a_eff, bv, cv);
      if (push) begin
         q1.push_back(e);
         q4.push_back(e);
      end
      model_y = e.y;
      select  = op;
      a       = av;
      b       = bv;
      cin     = cv;
      acc_sel = acc;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      acc_sel = 1'b0;
   endtask

   // Observes both instances until each has signalled done (bounded); reports
   // latency in cycles after the accepting edge, captured results, done width
   // and whether y stayed put outside the done cycle.
   task automatic wait_done(input int t0, output int l1, output int l4, output res_t g1,
                            output res_t g4, output int c1, output int c4, output bit held);
      logic [15:0] p1;
      logic [15:0] p4;
      p1 = i1.y; p4 = i4.y;
      l1 = -1; l4 = -1; c1 = 0; c4 = 0; held = 1'b1; g1 = '0; g4 = '0;
      for (int t = t0; t < t0 + 40; t++) begin
         if (i1.done) begin
            c1++;
            if (l1 < 0) begin l1 = t; g1 = {i1.y, i1.cout, i1.zero, i1.ovf, i1.illegal}; end
         end else if (i1.y !== p1) held = 1'b0;
         if (i4.done) begin
            c4++;
            if (l4 < 0) begin l4 = t; g4 = {i4.y, i4.cout, i4.zero, i4.ovf, i4.illegal}; end
         end else if (i4.y !== p4) held = 1'b0;
         p1 = i1.y; p4 = i4.y;
         if (l1 >= 0 && l4 >= 0 && t > l1 && t > l4) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [21:0] want;
      want = {16'h0, 6'b010000};
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({i1.y, i1.cout, i1.zero, i1.ovf, i1.illegal, i1.busy, i1.done} !== want) begin
         n_err++; $display("FAIL reset_x1 got %h want %h", {i1.y, i1.cout, i1.zero, i1.ovf, i1.illegal, i1.busy, i1.done}, want); end
      n_cmp++; if ({i4.y, i4.cout, i4.zero, i4.ovf, i4.illegal, i4.busy, i4.done} !== want) begin
         n_err++; $display("FAIL reset_x4 got %h want %h", {i4.y, i4.cout, i4.zero, i4.ovf, i4.illegal, i4.busy, i4.done}, want); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      drive_op(5'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
      n_cmp++; if ({i1.busy, i4.busy} !== 2'b11) begin n_err++; $display("FAIL add_busy got %b want 11", {i1.busy, i4.busy}); end
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL add_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL add_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g1 !== res_t'({16'h0100, 4'b0000})) begin n_err++; $display("FAIL add_const got %h want %h", g1, {16'h0100, 4'b0000}); end
      n_cmp++; if (l1 != 17) begin n_err++; $display("FAIL add_lat_x1 got %0d want 17", l1); end
      n_cmp++; if (l4 != 5) begin n_err++; $display("FAIL add_lat_x4 got %0d want 5", l4); end
      n_cmp++; if (c1 != 1 || c4 != 1) begin n_err++; $display("FAIL add_done_width got %0d/%0d want 1/1", c1, c4); end
      n_cmp++; if (!h) begin n_err++; $display("FAIL add_y_hold got changed want stable"); end
      n_cmp++; if ({i1.busy, i4.busy} !== 2'b00) begin n_err++; $display("FAIL add_busy_clr got %b want 00", {i1.busy, i4.busy}); end
   endtask

   task automatic test_sub_wrap();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      drive_op(5'd1, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL sub_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL sub_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g1 !== res_t'({16'h7FFF, 4'b1010})) begin n_err++; $display("FAIL sub_const got %h want %h", g1, {16'h7FFF, 4'b1010}); end
      drive_op(5'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL wrap_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL wrap_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g4 !== res_t'({16'h0000, 4'b1100})) begin n_err++; $display("FAIL wrap_const got %h want %h", g4, {16'h0000, 4'b1100}); end
   endtask

   task automatic test_busy_ignore();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      drive_op(5'd2, 16'h1234, 16'h0F0F, 1'b1, 1'b0, 1'b1);
      @(negedge clk); @(negedge clk);
      select = 5'd8; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL adc_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL adc_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g4.y !== 16'h2144) begin n_err++; $display("FAIL adc_const got %h want 2144", g4.y); end
      n_cmp++; if (l4 != 5 || l1 != 17) begin n_err++; $display("FAIL adc_lat got %0d/%0d want 17/5", l1, l4); end
      n_cmp++; if (c1 != 1 || c4 != 1) begin n_err++; $display("FAIL adc_done_width got %0d/%0d want 1/1", c1, c4); end
      n_cmp++; if (!h) begin n_err++; $display("FAIL adc_y_hold got changed want stable"); end
   endtask

   task automatic test_illegal();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      drive_op(5'd20, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL ill_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL ill_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g1 !== res_t'({16'h0000, 4'b0101})) begin n_err++; $display("FAIL ill_const got %h want %h", g1, {16'h0000, 4'b0101}); end
      drive_op(5'd8, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL xor_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL xor_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g4 !== res_t'({16'h5555, 4'b0000})) begin n_err++; $display("FAIL xor_const got %h want %h", g4, {16'h5555, 4'b0000}); end
   endtask

   task automatic test_reset_mid_run();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h; int nd;
      logic [21:0] want;
      want = {16'h0, 6'b010000};
      drive_op(5'd0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({i1.y, i1.cout, i1.zero, i1.ovf, i1.illegal, i1.busy, i1.done} !== want) begin
         n_err++; $display("FAIL midrst_x1 got %h want %h", {i1.y, i1.cout, i1.zero, i1.ovf, i1.illegal, i1.busy, i1.done}, want); end
      n_cmp++; if ({i4.y, i4.cout, i4.zero, i4.ovf, i4.illegal, i4.busy, i4.done} !== want) begin
         n_err++; $display("FAIL midrst_x4 got %h want %h", {i4.y, i4.cout, i4.zero, i4.ovf, i4.illegal, i4.busy, i4.done}, want); end
      @(negedge clk);
      rst = 1'b0;
      model_y = 16'h0;
      nd = 0;
      for (int t = 0; t < 25; t++) begin
         if (i1.done || i4.done) nd++;
         @(negedge clk);
      end
      n_cmp++; if (nd != 0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses want 0", nd); end
      drive_op(5'd4, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL inc_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL inc_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g1 !== res_t'({16'h0000, 4'b1100})) begin n_err++; $display("FAIL inc_const got %h want %h", g1, {16'h0000, 4'b1100}); end
   endtask

   task automatic test_opcodes();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      logic [4:0] op;
      for (int k = 0; k < 17; k++) begin
         op = (k == 16) ? 5'd31 : 5'(k);
         drive_op(op, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
         wait_done(0, l1, l4, g1, g4, c1, c4, h);
         e1 = q1.pop_front(); e4 = q4.pop_front();
         n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL op%0d_x1 got %h want %h", op, g1, e1); end
         n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL op%0d_x4 got %h want %h", op, g4, e4); end
      end
   endtask

   task automatic test_back_to_back();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      drive_op(5'd6, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL b2b_and got %h want %h", g1, e1); end
      drive_op(5'd5, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL b2b_dec got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== res_t'({16'h7FFF, 4'b1010})) begin n_err++; $display("FAIL b2b_dec_const got %h want %h", g4, {16'h7FFF, 4'b1010}); end
      n_cmp++; if (l1 != 17) begin n_err++; $display("FAIL b2b_lat got %0d want 17", l1); end
   endtask

   task automatic test_acc();
      res_t e1, e4, g1, g4; int l1, l4, c1, c4; bit h;
      logic [15:0] want;
`ifdef SEQ_SLICE_ALU_ACC_EN
      want = 16'd10;
`else
      want = 16'd2;
`endif
      drive_op(5'd0, 16'd5, 16'd3, 1'b0, 1'b0, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1.y !== 16'd8) begin n_err++; $display("FAIL acc_first got %h want 0008", g1.y); end
      drive_op(5'd0, 16'd0, 16'd2, 1'b0, 1'b1, 1'b1);
      wait_done(0, l1, l4, g1, g4, c1, c4, h);
      e1 = q1.pop_front(); e4 = q4.pop_front();
      n_cmp++; if (g1 !== e1) begin n_err++; $display("FAIL acc_x1 got %h want %h", g1, e1); end
      n_cmp++; if (g4 !== e4) begin n_err++; $display("FAIL acc_x4 got %h want %h", g4, e4); end
      n_cmp++; if (g4.y !== want) begin n_err++; $display("FAIL acc_const got %h want %h", g4.y, want); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_wrap();
      test_busy_ignore();
      test_illegal();
      test_reset_mid_run();
      test_opcodes();
      test_back_to_back();
      test_acc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "bench did not complete");
   end
endmodule
